fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end that drives the program ROM (`rom_module`) as its reader. It owns the program counter, issues read requests on the ROM's `ce`/`addr` port, absorbs the ROM's one-cycle registered read latency, and delivers instructions tagged with their PC to decode through a valid/ready handshake. Branch redirects flush in-flight and buffered fetches.

## Interface
- `ADDR_W`, 16, byte-address width; matches the ROM `addr` port.
- `DATA_W`, 32, instruction width; matches the ROM `dout` port.
- `RESET_PC`, 16'h0000, first fetch address after reset.
- `FIFO_DEPTH`, 2, instruction buffer entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_en`  in  1  permits new ROM requests; buffered instructions still drain while low.
- `rom_ce`  out  1  ROM read enable.
- `rom_addr`  out  ADDR_W  ROM byte address; low 2 bits always 0.
- `rom_dout`  in  DATA_W  ROM read data, valid the cycle after an accepted request.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid entry.
- `instr_ready`  in  1  decode accepts the entry this cycle.
- `instr`  out  DATA_W  instruction at the FIFO head.
- `instr_pc`  out  ADDR_W  byte address of `instr`.
- `redirect_valid`  in  1  branch or jump; flush and restart fetch.
- `redirect_pc`  in  ADDR_W  new fetch address; bits [1:0] ignored and forced to 0.

## Operation
- State: `pc`, `pend` (request in flight), `pend_pc`, FIFO of {instr, pc} with `count`.
- Reset values: `pc=RESET_PC`, `pend=0`, `count=0`, `rom_ce=0`, `instr_valid=0`, `instr=0`, `instr_pc=0`.
- Issue: `rom_ce = fetch_en & ~redirect_valid & ((count + pend < FIFO_DEPTH) | pop)`, where `pop = instr_valid & instr_ready`. `rom_addr = pc`.
- On an issue edge: `pend<=1`, `pend_pc<=pc`, `pc<=pc+4`. `pc` wraps modulo 2^ADDR_W, so 16'hFFFC is followed by 16'h0000.
- On the edge after an issue, `rom_dout` and `pend_pc` are written to the FIFO tail, and `pend` clears unless a new request was issued.
- Pop on `instr_valid & instr_ready`. Push and pop in the same cycle leave `count` unchanged.
- The credit rule guarantees the FIFO never overflows. A push is never dropped.
- Redirect (`redirect_valid=1`):
  - `instr_valid` is forced to 0 and `rom_ce` to 0 that cycle.
  - At the edge: FIFO flushed (`count=0`), `pend` cleared, and any ROM data returning next cycle discarded.
  - `pc <= {redirect_pc[ADDR_W-1:2], 2'b00}`.
  - Redirect takes priority over push, pop and issue.
- `fetch_en` low: no issue. A pending response is still captured, and the FIFO still drains.
- `rst_n` asserted mid-operation: all state returns to reset values immediately. The ROM's response to any pending request is ignored.

## Timing
- Request in cycle N: the ROM registers at the end of N, the FIFO captures at the end of N+1, and `instr_valid` rises in N+2. Fetch latency is 2 cycles.
- First request is in the first cycle after `rst_n` deasserts, provided `fetch_en=1`.
- With `instr_ready` held high, throughput is 1 instruction/cycle for `FIFO_DEPTH>=2`.
- Redirect in cycle N: first request to the new PC in N+1, its `instr_valid` in N+3.
- Back-pressure: `instr_ready` low with a full FIFO stops `rom_ce` in the same cycle. `instr`/`instr_pc` hold stable while `instr_valid & ~instr_ready`.

## Configuration
- `FETCH_PERF_EN` defined: adds output `perf_fetch_cnt` (32 bits, increments on each issued request) and output `perf_stall_cnt` (32 bits, increments each cycle with `instr_valid & ~instr_ready`). Both reset to 0, wrap at 2^32, and are not cleared by redirect.
- `FETCH_PERF_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
The ROM model is preloaded with `mem[i] = i<<8`.
- Reset release, `fetch_en=1`, `instr_ready=1` -> `instr_valid` rises 2 cycles after the first `rom_ce`. Then it delivers (pc, instr) = (0x0000, 0x00000000), (0x0004, 0x00000100), (0x0008, 0x00000200), one per cycle.
- Hold `instr_ready=0` for 5 cycles -> `rom_ce` drops once `count + pend = 2`. `instr` stays at 0x00000000 with `instr_pc` 0x0000. On release, the sequence continues with no gap or duplicate.
- Redirect to 0x0011 while 2 entries are buffered -> both are flushed and the in-flight response is dropped. The next delivered entry is pc 0x0010, instr 0x00000400, 3 cycles after the redirect.
- Redirect to 0xFFFC -> fetches are issued at 0xFFFC, then 0x0000, with the PC wrapping correctly.
- Deassert `rst_n` asynchronously mid-stream with 1 request pending -> `instr_valid` and `rom_ce` go to 0 immediately. After release, the first delivered instruction is pc 0x0000.
- `FETCH_PERF_EN` run: 10 issued fetches and 5 stall cycles -> `perf_fetch_cnt=10`, `perf_stall_cnt=5`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, ROM request/response, {instr, pc} buffer, redirect flush.
// Optional perf counters (perf_fetch_cnt, perf_stall_cnt) are built when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pend_pc_q;
    logic              pend_q;
    logic [DATA_W-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic pop;
    logic push;
    logic credit;

    // Buffered entries plus the request in flight must fit, so a response is never dropped.
    assign credit      = (int'(count_q) + int'(pend_q)) < FIFO_DEPTH;
    assign instr_valid = (count_q != '0) && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign push        = pend_q;
    assign rom_ce      = rst_n && fetch_en && !redirect_valid && (credit || pop);
    assign rom_addr    = pc_q;
    assign instr       = fifo_instr_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC & ALIGN_MASK;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else if (redirect_valid) begin
            // Clearing pend_q discards the response of the last request still in the ROM.
            pc_q     <= redirect_pc & ALIGN_MASK;
            pend_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pend_q <= rom_ce;
            if (rom_ce) begin
                pend_pc_q <= pc_q;
                pc_q      <= pc_q + ADDR_W'(4);
            end
            if (push) begin
                fifo_instr_q[wr_ptr_q] <= rom_dout;
                fifo_pc_q[wr_ptr_q]    <= pend_pc_q;
                wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Counters survive redirects; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (rom_ce) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (instr_valid && !instr_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM model, program-order scoreboard, directed timing checks, random traffic.
module tb_fetch_unit;
    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_en = 1'b0;
    logic          instr_ready = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout = '0;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] ins;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] next_gen = '0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_issue = 0;
    int            n_stall = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_instr = '0;
    logic [AW-1:0] prev_pc = '0;
    logic [AW-1:0] held_pc;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .rom_ce         (rom_ce),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ROM image: word i holds i<<8.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {18'b0, a[AW-1:2]} << 8;
    endfunction

    always @(posedge clk) begin
        if (rom_ce) rom_dout <= rom_word(rom_addr);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Expected stream is simply program order from the last restart address.
    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: next_gen, ins: rom_word(next_gen)});
            next_gen = next_gen + 16'd4;
        end
    endtask

    task automatic restart(input logic [AW-1:0] a);
        exp_q.delete();
        next_gen = a & 16'hFFFC;
        topup();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        topup();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            n_issue    = 0;
            n_stall    = 0;
            stall_prev = 1'b0;
        end else begin
            if (rom_ce) begin
                n_issue++;
                chk("rom_addr_align", 32'(rom_addr[1:0]), 32'd0);
            end
            if (instr_valid && !instr_ready) n_stall++;
            if (stall_prev && instr_valid) begin
                chk("hold_instr", instr, prev_instr);
                chk("hold_pc", 32'(instr_pc), 32'(prev_pc));
            end
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_empty: got pc %0h expected no delivery", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", 32'(instr_pc), 32'(e.pc));
                    chk("sb_instr", instr, e.ins);
                end
            end
            stall_prev = instr_valid && !instr_ready;
            prev_instr = instr;
            prev_pc    = instr_pc;
        end
    end

    initial begin
        rst_n       = 1'b0;
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        restart(16'h0000);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_rom_ce", 32'(rom_ce), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);

        // Release mid-cycle: this cycle issues, valid two cycles later.
        rst_n = 1'b1;
        #1;
        chk("first_ce", 32'(rom_ce), 32'd1);
        chk("first_addr", 32'(rom_addr), 32'd0);
        cyc(); #3;
        chk("lat_valid_n1", 32'(instr_valid), 32'd0);
        cyc(); #3;
        chk("lat_valid_n2", 32'(instr_valid), 32'd1);
        chk("first_pc", 32'(instr_pc), 32'd0);
        chk("first_instr", instr, 32'd0);

        // Back-pressure for 5 cycles.
        repeat (4) cyc();
        instr_ready = 1'b0;
        held_pc = instr_pc;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("stall_pc", 32'(instr_pc), 32'(held_pc));
            cyc();
        end
        #3;
        chk("stall_ce", 32'(rom_ce), 32'd0);
        chk("stall_valid", 32'(instr_valid), 32'd1);
        cyc();
        instr_ready = 1'b1;

        // Redirect with a full buffer.
        repeat (3) cyc();
        instr_ready = 1'b0;
        repeat (3) cyc();
        #3;
        chk("full_ce", 32'(rom_ce), 32'd0);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0011;
        instr_ready    = 1'b1;
        restart(16'h0011);
        #3;
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_ce", 32'(rom_ce), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        #3;
        chk("redir_n1_ce", 32'(rom_ce), 32'd1);
        chk("redir_n1_addr", 32'(rom_addr), 32'h10);
        chk("redir_n1_valid", 32'(instr_valid), 32'd0);
        cyc(); #3;
        chk("redir_n2_valid", 32'(instr_valid), 32'd0);
        cyc(); #3;
        chk("redir_n3_valid", 32'(instr_valid), 32'd1);
        chk("redir_n3_pc", 32'(instr_pc), 32'h10);
        chk("redir_n3_instr", instr, 32'h400);

        // Redirect near the top of the address space.
        repeat (3) cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        restart(16'hFFFE);
        cyc();
        redirect_valid = 1'b0;
        #3;
        chk("wrap_ce0", 32'(rom_ce), 32'd1);
        chk("wrap_addr0", 32'(rom_addr), 32'hFFFC);
        cyc(); #3;
        chk("wrap_ce1", 32'(rom_ce), 32'd1);
        chk("wrap_addr1", 32'(rom_addr), 32'h0000);
        cyc(); #3;
        chk("wrap_valid", 32'(instr_valid), 32'd1);
        chk("wrap_pc", 32'(instr_pc), 32'hFFFC);
        chk("wrap_instr", instr, 32'h003FFF00);

        // Asynchronous reset while a request is in flight.
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        restart(16'h0000);
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_ce", 32'(rom_ce), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("arst_rel_ce", 32'(rom_ce), 32'd1);
        chk("arst_rel_addr", 32'(rom_addr), 32'd0);
        cyc();
        cyc(); #3;
        chk("arst_first_valid", 32'(instr_valid), 32'd1);
        chk("arst_first_pc", 32'(instr_pc), 32'd0);

        // Random traffic against the program-order scoreboard.
        for (int c = 0; c < 1500; c++) begin
            cyc();
            fetch_en    = ($urandom_range(0, 7) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 16'($urandom);
                restart(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        cyc();
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        instr_ready    = 1'b1;
        repeat (6) cyc();
        #3;
        chk("drain_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_PERF_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'(n_issue));
        chk("perf_stall_cnt", perf_stall_cnt, 32'(n_stall));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
